// File: rtl/i2c_oled_target.sv
// I2C write target modelling the SSD1306 OLED interface: START/STOP and bit decode, address match, control-byte decode, command/data byte strobes.
// Define READ_STATUS_EN to also answer read addresses with bytes sampled from status_in.
module i2c_oled_target #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
   parameter int         SYNC_STAGES = 2      // must be >= 2
) (
   input  logic       CLK,
   input  logic       NRST,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       byte_is_data,
   output logic       frame_active,
   input  logic [7:0] status_in
);

`ifdef READ_STATUS_EN
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, BYTE, BYTE_ACK, IGNORE, READ_TX, READ_ACK
   } state_e;
`else
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, BYTE, BYTE_ACK, IGNORE
   } state_e;
`endif

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic [7:0]             shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   co_q, co_d;
   logic                   dc_q, dc_d;
   logic                   sda_oe_q, sda_oe_d;
   logic [7:0]             byte_out_q, byte_out_d;
   logic                   byte_valid_q, byte_valid_d;
   logic                   byte_is_data_q, byte_is_data_d;
   logic                   frame_active_q, frame_active_d;
`ifdef READ_STATUS_EN
   logic                   rd_q, rd_d;
   logic                   mack_q, mack_d;
`else
   logic                   unused_status;
   assign unused_status = ^status_in;
`endif

   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte;
   logic       addr_hit;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   // START/STOP need SCL high in both samples so our own SDA changes (made while SCL is low) never look like one.
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign rx_byte   = {shift_q[6:0], sda_s};
   assign addr_hit  = (rx_byte[7:1] == SLAVE_ADDR);

   always_comb begin
      // NOTE: every _d gets a default before any branch, otherwise the unassigned paths infer latches.
      scl_sync_d     = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d     = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d     = scl_s;
      sda_prev_d     = sda_s;
      state_d        = state_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      co_d           = co_q;
      dc_d           = dc_q;
      sda_oe_d       = sda_oe_q;
      byte_out_d     = byte_out_q;
      byte_valid_d   = 1'b0;
      byte_is_data_d = byte_is_data_q;
      frame_active_d = frame_active_q;
`ifdef READ_STATUS_EN
      rd_d           = rd_q;
      mack_d         = mack_q;
`endif

      if (stop_det) begin
         state_d        = IDLE;
         sda_oe_d       = 1'b0;
         frame_active_d = 1'b0;
`ifdef READ_STATUS_EN
         mack_d         = 1'b0;
`endif
      end else if (start_det) begin
         state_d        = ADDR;
         bit_cnt_d      = 3'd0;
         sda_oe_d       = 1'b0;
         frame_active_d = 1'b0;
`ifdef READ_STATUS_EN
         mack_d         = 1'b0;
`endif
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef READ_STATUS_EN
                  rd_d = rx_byte[0];
`endif
                  if (addr_hit && !rx_byte[0]) begin
                     state_d        = ADDR_ACK;
                     frame_active_d = 1'b1;
                  end
`ifdef READ_STATUS_EN
                  else if (addr_hit) begin
                     state_d        = ADDR_ACK;
                     frame_active_d = 1'b1;
                  end
`endif
                  else begin
                     state_d = IGNORE;
                  end
               end
            end
            CTRL: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  co_d    = rx_byte[7];
                  dc_d    = rx_byte[6];
                  state_d = CTRL_ACK;
               end
            end
            BYTE: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_out_d     = rx_byte;
                  byte_is_data_d = dc_q;
                  byte_valid_d   = 1'b1;
                  state_d        = BYTE_ACK;
               end
            end
            // First SCL fall pulls SDA low, the second releases it; sda_oe_q itself marks the phase.
            ADDR_ACK, CTRL_ACK, BYTE_ACK: if (scl_fall) begin
               if (!sda_oe_q) begin
                  sda_oe_d = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 3'd0;
                  case (state_q)
                     ADDR_ACK: state_d = CTRL;
                     CTRL_ACK: state_d = BYTE;
                     default:  state_d = co_q ? CTRL : BYTE;
                  endcase
`ifdef READ_STATUS_EN
                  if (state_q == ADDR_ACK && rd_q) begin
                     shift_d  = status_in;
                     sda_oe_d = ~status_in[7];
                     state_d  = READ_TX;
                  end
`endif
               end
            end
`ifdef READ_STATUS_EN
            READ_TX: if (scl_fall) begin
               shift_d   = {shift_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  sda_oe_d = 1'b0;
                  mack_d   = 1'b0;
                  state_d  = READ_ACK;
               end else begin
                  sda_oe_d = ~shift_q[6];
               end
            end
            READ_ACK: begin
               if (scl_rise) begin
                  if (sda_s) state_d = IGNORE;
                  else       mack_d  = 1'b1;
               end else if (scl_fall && mack_q) begin
                  mack_d    = 1'b0;
                  shift_d   = status_in;
                  sda_oe_d  = ~status_in[7];
                  bit_cnt_d = 3'd0;
                  state_d   = READ_TX;
               end
            end
`endif
            IDLE, IGNORE: begin
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         scl_sync_q     <= '1;
         sda_sync_q     <= '1;
         scl_prev_q     <= 1'b1;
         sda_prev_q     <= 1'b1;
         state_q        <= IDLE;
         shift_q        <= 8'h00;
         bit_cnt_q      <= 3'd0;
         co_q           <= 1'b0;
         dc_q           <= 1'b0;
         sda_oe_q       <= 1'b0;
         byte_out_q     <= 8'h00;
         byte_valid_q   <= 1'b0;
         byte_is_data_q <= 1'b0;
         frame_active_q <= 1'b0;
`ifdef READ_STATUS_EN
         rd_q           <= 1'b0;
         mack_q         <= 1'b0;
`endif
      end else begin
         scl_sync_q     <= scl_sync_d;
         sda_sync_q     <= sda_sync_d;
         scl_prev_q     <= scl_prev_d;
         sda_prev_q     <= sda_prev_d;
         state_q        <= state_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         co_q           <= co_d;
         dc_q           <= dc_d;
         sda_oe_q       <= sda_oe_d;
         byte_out_q     <= byte_out_d;
         byte_valid_q   <= byte_valid_d;
         byte_is_data_q <= byte_is_data_d;
         frame_active_q <= frame_active_d;
`ifdef READ_STATUS_EN
         rd_q           <= rd_d;
         mack_q         <= mack_d;
`endif
      end
   end

   assign sda_oe       = sda_oe_q;
   assign byte_out     = byte_out_q;
   assign byte_valid   = byte_valid_q;
   assign byte_is_data = byte_is_data_q;
   assign frame_active = frame_active_q;

endmodule

// File: tb/tb_i2c_oled_target.sv
// Bench for i2c_oled_target: bit-banged I2C master on an open-drain SDA, strobe monitor, and a transaction-level reference model.
module tb_i2c_oled_target;

   localparam logic [6:0] TGT = 7'h3C;
   localparam int         Q   = 40;   // quarter SCL period; SCL = 16 CLK cycles

   typedef logic [7:0] bq_t[$];
   typedef logic [8:0] sq_t[$];       // {is_data, byte}
   typedef bit         bitq_t[$];

   logic       CLK    = 1'b0;
   logic       NRST   = 1'b1;
   logic       scl_m  = 1'b1;
   logic       sda_m  = 1'b1;
   logic [7:0] status = 8'h00;
   logic       sda_oe, byte_valid, byte_is_data, frame_active;
   logic [7:0] byte_out;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   i2c_oled_target dut (
      .CLK(CLK), .NRST(NRST), .scl_in(scl_m), .sda_in(sda_line),
      .sda_oe(sda_oe), .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_is_data(byte_is_data), .frame_active(frame_active), .status_in(status)
   );

   always #5 CLK = ~CLK;

   int   n_cmp = 0;
   int   n_err = 0;
   sq_t  got_q;
   int   oe_cycles = 0;
   int   dbl_strobe = 0;
   logic valid_prev = 1'b0;

   always @(negedge CLK) begin
      if (byte_valid) got_q.push_back({byte_is_data, byte_out});
      if (sda_oe) oe_cycles <= oe_cycles + 1;
      if (byte_valid && valid_prev) dbl_strobe <= dbl_strobe + 1;
      valid_prev <= byte_valid;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   // ---------------- bus driver ----------------
   task automatic bus_start;
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0;
   endtask

   task automatic bus_stop;
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q; #Q;
   endtask

   task automatic send_bit(input logic b, output logic s);
      #Q; sda_m = b; #Q; scl_m = 1'b1; #Q; s = sda_line; #Q; scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack, output logic clean);
      logic s;
      clean = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i], s);
         if (s !== b[i]) clean = 1'b0;
      end
      send_bit(1'b1, s);
      ack = (s === 1'b0);
   endtask

   task automatic read_bits(output logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         v[i] = s;
      end
   endtask

   task automatic xfer(input bq_t bytes, input bit do_stop, output bitq_t acks,
                       output logic fa, output logic clean);
      logic a, c;
      acks = {};
      fa = 1'b0;
      clean = 1'b1;
      got_q.delete();
      bus_start();
      foreach (bytes[i]) begin
         send_byte(bytes[i], a, c);
         acks.push_back(a);
         if (!c) clean = 1'b0;
         if (i == 0) fa = frame_active;
      end
      if (do_stop) bus_stop();
   endtask

   // Transaction-level model of a complete write frame.
   task automatic ref_model(input bq_t bytes, output bitq_t acks, output sq_t strobes);
      logic [7:0] ctrl;
      int         i;
      bit         hit;
      acks = {};
      strobes = {};
      hit = (bytes[0][7:1] == TGT) && (bytes[0][0] == 1'b0);
      foreach (bytes[k]) acks.push_back(hit);
      if (!hit) return;
      i = 1;
      while (i < bytes.size()) begin
         ctrl = bytes[i];
         i++;
         if (ctrl[7]) begin
            if (i < bytes.size()) begin
               strobes.push_back({ctrl[6], bytes[i]});
               i++;
            end
         end else begin
            while (i < bytes.size()) begin
               strobes.push_back({ctrl[6], bytes[i]});
               i++;
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      #1 NRST = 1'b0;
      #11;
      n_cmp++;
      if ({sda_oe, byte_out, byte_valid, byte_is_data, frame_active} !== 12'h000) begin
         n_err++;
         $display("FAIL reset outputs: got oe=%b out=%h v=%b d=%b fa=%b want all 0",
                  sda_oe, byte_out, byte_valid, byte_is_data, frame_active);
      end
      #8 NRST = 1'b1;
      #(4*Q);
   endtask

   task automatic test_cmd_stream;
      bitq_t acks;
      logic  fa, clean;
      sq_t   exp_s = '{9'h0A8, 9'h03F};
      xfer('{8'h78, 8'h00, 8'hA8, 8'h3F}, 1'b1, acks, fa, clean);
      foreach (acks[i]) begin
         n_cmp++;
         if (acks[i] !== 1'b1) begin n_err++; $display("FAIL cmd_stream ack[%0d]: got %b want 1", i, acks[i]); end
      end
      n_cmp++;
      if (got_q.size() != exp_s.size()) begin
         n_err++; $display("FAIL cmd_stream strobe count: got %0d want %0d", got_q.size(), exp_s.size());
      end
      for (int i = 0; i < exp_s.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_s[i]) begin n_err++; $display("FAIL cmd_stream strobe[%0d]: got %h want %h", i, got_q[i], exp_s[i]); end
      end
      n_cmp++;
      if (fa !== 1'b1) begin n_err++; $display("FAIL cmd_stream frame_active after addr: got %b want 1", fa); end
      n_cmp++;
      if (frame_active !== 1'b0) begin n_err++; $display("FAIL cmd_stream frame_active after stop: got %b want 0", frame_active); end
      n_cmp++;
      if (clean !== 1'b1) begin n_err++; $display("FAIL cmd_stream sda driven during data bits: got %b want 1", clean); end
   endtask

   task automatic test_wrong_addr;
      bitq_t acks;
      logic  fa, clean;
      int    oe0 = oe_cycles;
      xfer('{8'h7A, 8'h00}, 1'b1, acks, fa, clean);
      foreach (acks[i]) begin
         n_cmp++;
         if (acks[i] !== 1'b0) begin n_err++; $display("FAIL wrong_addr ack[%0d]: got %b want 0", i, acks[i]); end
      end
      n_cmp++;
      if (oe_cycles - oe0 != 0) begin n_err++; $display("FAIL wrong_addr sda_oe cycles: got %0d want 0", oe_cycles - oe0); end
      n_cmp++;
      if (got_q.size() != 0) begin n_err++; $display("FAIL wrong_addr strobe count: got %0d want 0", got_q.size()); end
      n_cmp++;
      if (fa !== 1'b0) begin n_err++; $display("FAIL wrong_addr frame_active: got %b want 0", fa); end
   endtask

   task automatic test_co_mode;
      bitq_t acks;
      logic  fa, clean;
      sq_t   exp_s = '{9'h0AF, 9'h155};
      xfer('{8'h78, 8'h80, 8'hAF, 8'hC0, 8'h55}, 1'b1, acks, fa, clean);
      foreach (acks[i]) begin
         n_cmp++;
         if (acks[i] !== 1'b1) begin n_err++; $display("FAIL co_mode ack[%0d]: got %b want 1", i, acks[i]); end
      end
      n_cmp++;
      if (got_q.size() != exp_s.size()) begin
         n_err++; $display("FAIL co_mode strobe count: got %0d want %0d", got_q.size(), exp_s.size());
      end
      for (int i = 0; i < exp_s.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_s[i]) begin n_err++; $display("FAIL co_mode strobe[%0d]: got %h want %h", i, got_q[i], exp_s[i]); end
      end
      n_cmp++;
      if (dbl_strobe != 0) begin n_err++; $display("FAIL co_mode byte_valid wider than 1 cycle: got %0d want 0", dbl_strobe); end
   endtask

   task automatic test_partial_stop;
      bitq_t acks;
      logic  fa, clean, s;
      xfer('{8'h78, 8'h40, 8'hFF}, 1'b0, acks, fa, clean);
      for (int i = 0; i < 4; i++) send_bit(1'b0, s);
      bus_stop();
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== 9'h1FF) begin
         n_err++; $display("FAIL partial_stop strobes: got n=%0d first=%h want n=1 first=1ff",
                           got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h000);
      end
      xfer('{8'h78}, 1'b1, acks, fa, clean);
      n_cmp++;
      if (acks[0] !== 1'b1 || fa !== 1'b1) begin
         n_err++; $display("FAIL partial_stop readdress: got ack=%b fa=%b want 1 1", acks[0], fa);
      end
      n_cmp++;
      if (got_q.size() != 0) begin n_err++; $display("FAIL partial_stop stray strobes: got %0d want 0", got_q.size()); end
   endtask

   task automatic test_async_reset;
      logic s;
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(((8'h78 >> i) & 8'h01) != 0, s);
      #(2*Q);
      n_cmp++;
      if (sda_oe !== 1'b1 || frame_active !== 1'b1) begin
         n_err++; $display("FAIL async_reset ack drive before reset: got oe=%b fa=%b want 1 1", sda_oe, frame_active);
      end
      #3 NRST = 1'b0;
      #1;
      n_cmp++;
      if ({sda_oe, byte_out, byte_valid, byte_is_data, frame_active} !== 12'h000) begin
         n_err++;
         $display("FAIL async_reset outputs: got oe=%b out=%h v=%b d=%b fa=%b want all 0",
                  sda_oe, byte_out, byte_valid, byte_is_data, frame_active);
      end
      #6 scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #Q NRST = 1'b1;
      #(2*Q);
   endtask

   task automatic test_read;
      logic       ack, clean, fa, s;
      logic [7:0] v;
      int         oe0;
      status = 8'hA5;
      got_q.delete();
      bus_start();
      send_byte(8'h79, ack, clean);
      fa = frame_active;
`ifdef READ_STATUS_EN
      n_cmp++;
      if (ack !== 1'b1 || fa !== 1'b1) begin n_err++; $display("FAIL read addr: got ack=%b fa=%b want 1 1", ack, fa); end
      read_bits(v);
      n_cmp++;
      if (v !== 8'hA5) begin n_err++; $display("FAIL read byte0: got %h want a5", v); end
      status = 8'h3C;
      send_bit(1'b0, s);
      read_bits(v);
      n_cmp++;
      if (v !== 8'h3C) begin n_err++; $display("FAIL read byte1: got %h want 3c", v); end
      send_bit(1'b1, s);
      oe0 = oe_cycles;
      read_bits(v);
      n_cmp++;
      if (oe_cycles - oe0 != 0) begin n_err++; $display("FAIL read drive after nack: got %0d cycles want 0", oe_cycles - oe0); end
`else
      oe0 = oe_cycles;
      n_cmp++;
      if (ack !== 1'b0 || fa !== 1'b0) begin n_err++; $display("FAIL read addr: got ack=%b fa=%b want 0 0", ack, fa); end
      read_bits(v);
      send_bit(1'b1, s);
      n_cmp++;
      if (oe_cycles - oe0 != 0) begin n_err++; $display("FAIL read sda driven: got %0d cycles want 0", oe_cycles - oe0); end
`endif
      bus_stop();
      n_cmp++;
      if (frame_active !== 1'b0 || got_q.size() != 0) begin
         n_err++; $display("FAIL read end: got fa=%b strobes=%0d want 0 0", frame_active, got_q.size());
      end
   endtask

   task automatic test_random;
      bq_t        bytes;
      bitq_t      acks, exp_a;
      sq_t        exp_s;
      logic       fa, clean;
      logic [6:0] other;
      for (int t = 0; t < 20; t++) begin
         bytes = {};
         if ($urandom_range(0, 3) == 0) begin
            other = 7'($urandom_range(0, 127));
            if (other == TGT) other = 7'h3D;
            bytes.push_back({other, 1'($urandom_range(0, 1))});
         end else begin
            bytes.push_back({TGT, 1'b0});
         end
         for (int k = $urandom_range(0, 5); k > 0; k--) bytes.push_back(8'($urandom_range(0, 255)));
         ref_model(bytes, exp_a, exp_s);
         xfer(bytes, 1'b1, acks, fa, clean);
         foreach (acks[i]) begin
            n_cmp++;
            if (acks[i] !== exp_a[i]) begin n_err++; $display("FAIL random t%0d ack[%0d]: got %b want %b", t, i, acks[i], exp_a[i]); end
         end
         n_cmp++;
         if (got_q.size() != exp_s.size()) begin
            n_err++; $display("FAIL random t%0d strobe count: got %0d want %0d", t, got_q.size(), exp_s.size());
         end
         for (int i = 0; i < exp_s.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_s[i]) begin n_err++; $display("FAIL random t%0d strobe[%0d]: got %h want %h", t, i, got_q[i], exp_s[i]); end
         end
         n_cmp++;
         if (fa !== exp_a[0] || frame_active !== 1'b0 || clean !== 1'b1) begin
            n_err++; $display("FAIL random t%0d frame/clean: got fa=%b after_stop=%b clean=%b want %b 0 1",
                              t, fa, frame_active, clean, exp_a[0]);
         end
      end
      n_cmp++;
      if (dbl_strobe != 0) begin n_err++; $display("FAIL random byte_valid wider than 1 cycle: got %0d want 0", dbl_strobe); end
   endtask

   initial begin
      test_reset();
      test_cmd_stream();
      test_wrong_addr();
      test_co_mode();
      test_partial_stop();
      test_async_reset();
      test_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_oled_target.md
Name: i2c_oled_target

Overview:
I2C target (responder) model of the SSD1306 OLED write interface, the far end of the OLED init/command master. Oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit slave address. It ACKs accepted bytes and decodes the control byte (Co, D/C#), then streams received command/data bytes to a consumer (display model or bench scoreboard).

Parameters:
SLAVE_ADDR, 7'h3C, 7-bit target address; bit 0 of the address byte is R/W#.
SYNC_STAGES, 2, flops in the scl_in/sda_in synchronizers (min 2).

Ports:
CLK  in  1  system clock, must be at least 8x the SCL rate.
NRST  in  1  asynchronous active-low reset.
scl_in  in  1  raw SCL line.
sda_in  in  1  raw SDA line.
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
byte_out  out  8  last received payload byte.
byte_valid  out  1  one-cycle strobe; byte_out/byte_is_data valid.
byte_is_data  out  1  1 = GDDRAM data (D/C#=1), 0 = command.
frame_active  out  1  1 while an addressed transaction is in progress.
status_in  in  8  status byte returned on reads (used only with READ_STATUS_EN).

Behaviour:
- Reset (async): sda_oe=0, byte_out=0, byte_valid=0, byte_is_data=0, frame_active=0; FSM to IDLE; shift register and bit counter cleared.
- Inputs pass through SYNC_STAGES flops. Edges are detected on synchronized values.
- START = sda falls while scl high; STOP = sda rises while scl high.
- Data bits are sampled on the SCL rising edge, MSB first. The bit counter runs 0..7.
- States: IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, BYTE, BYTE_ACK, READ_TX, READ_ACK, IGNORE.
- START from any state (incl. repeated START): go to ADDR, clear the counter, sda_oe=0, frame_active=0.
- STOP from any state: go to IDLE, sda_oe=0, frame_active=0. A partial byte is discarded with no strobe.
- ADDR: after 8 bits, if [7:1]==SLAVE_ADDR and R/W#=0, go to ADDR_ACK and set frame_active=1. Otherwise go to IGNORE and never drive sda_oe.
- ACK timing (all *_ACK states): sda_oe goes 1 on the SCL falling edge after the 8th bit and goes 0 on the next SCL falling edge. No other cycles drive SDA.
- CTRL: the received byte latches Co=bit7 and DC=bit6; bits [5:0] are ignored. ACK, then go to BYTE.
- BYTE, data path:
  - In the CLK cycle after the 8th SCL rise is detected: byte_out=shifted byte, byte_is_data=DC, byte_valid=1 for exactly one cycle. ACK follows.
  - Co=0: following bytes stay in BYTE with the same DC until STOP or START.
  - Co=1: the next byte returns to CTRL (single-byte control mode).
- IGNORE: passive until START/STOP. No strobes.
- A simultaneous START detection and 8th-bit sample cannot occur, since they need scl high vs. a rising edge. If a START and a STOP occur in the same cycle, STOP wins.
- byte_valid never asserts outside BYTE. Back-to-back strobes are at least 9 SCL periods apart.

Optional Feature:
READ_STATUS_EN:
- Defined: an address match with R/W#=1 is ACKed, frame_active=1, then READ_TX.
  - status_in is latched at the ACK release; bits are driven MSB first, with sda_oe=~bit updated on each SCL falling edge.
  - After 8 bits, release SDA and sample the master bit on the SCL rise (READ_ACK).
  - Master ACK (0): relatch status_in and repeat. NACK (1): go to IGNORE.
- Undefined: read addresses are NACKed and go to IGNORE; status_in is unused; READ_TX/READ_ACK are absent.

Test Plan:
1. START, 0x78, 0x00, 0xA8, 0x3F, STOP -> 4 ACKs; byte_valid pulses twice (0xA8 then 0x3F) with byte_is_data=0; frame_active falls at STOP.
2. START, 0x7A, 0x00, STOP -> sda_oe never 1, no byte_valid, frame_active stays 0.
3. START, 0x78, 0x80, 0xAF, 0xC0, 0x55, STOP -> strobes 0xAF (is_data=0) then 0x55 (is_data=1).
4. START, 0x78, 0x40, 0xFF, 4 bits of 0x00, STOP -> one strobe 0xFF is_data=1, partial byte dropped, FSM IDLE; next START, 0x78 ACKed normally.
5. NRST low while sda_oe=1 during an ACK -> sda_oe=0 in the same cycle (async); all outputs at reset values.
6. START, 0x79, status_in=0xA5, master NACK -> with READ_STATUS_EN: ACK, SDA bits 1,0,1,0,0,1,0,1 then release. Without the macro: NACK, no SDA drive.
